// File: rtl/tm1638_pkg.sv
// Shared types and segment constants for the tm1638 display path.
// Producers use SEG_DIGIT to map a hex nibble onto hgfedcba.
package tm1638_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam int W_SEG = 8;

    localparam logic [W_SEG-1:0] SEG_BLANK = '0;

    localparam logic [W_SEG-1:0] SEG_DIGIT [0:15] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F,
        8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C,
        8'h39, 8'h5E, 8'h79, 8'h71
    };

endpackage

// File: rtl/tm1638_seg_buffer.sv
// Double-buffered segment store: producer writes shadow, swap copies
// every digit of shadow into active in a single edge.
module tm1638_seg_buffer
    import tm1638_pkg::*;
#(
    parameter int w_digit = 8,
    parameter int w_seg   = W_SEG,
    parameter int w_idx   = $clog2(w_digit)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [w_idx-1:0] wr_idx,
    input  logic [w_seg-1:0] wr_seg,
    input  logic             swap,
    input  logic [w_idx-1:0] rd_idx,
    output logic [w_seg-1:0] rd_seg
);

    logic [w_seg-1:0] shadow [w_digit];
    logic [w_seg-1:0] active [w_digit];

    // Out-of-range write indices match no entry and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < w_digit; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < w_digit; i++) begin
                if (wr_en && (wr_idx == w_idx'(i))) begin
                    shadow[i] <= wr_seg;
                end
                if (swap) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    // Forward the incoming copy so a digit loaded on the swap edge
    // already sees the new frame's data.
    always_comb begin
        rd_seg = active[rd_idx];
        if (swap) begin
            rd_seg = shadow[rd_idx];
        end
    end

endmodule

// File: rtl/tm1638_digit_scanner.sv
// Time-multiplexed digit scanner for the tm1638 strobe bus with
// blank gaps between digits and frame-aligned buffer commits.
module tm1638_digit_scanner
    import tm1638_pkg::*;
#(
    parameter int w_digit      = 8,
    parameter int w_seg        = W_SEG,
    parameter int dwell_cycles = 1000,
    parameter int blank_cycles = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(w_digit)-1:0] wr_idx,
    input  logic [w_seg-1:0]           wr_seg,
    input  logic                       commit,
    output logic                       commit_pend,
    output logic                       frame_start,
    output logic [w_seg-1:0]           hgfedcba,
    output logic [w_digit-1:0]         digit
);

    localparam int w_idx = $clog2(w_digit);
    localparam int max_c = (dwell_cycles > blank_cycles) ?
                           dwell_cycles : blank_cycles;
    localparam int w_tmr = $clog2(max_c + 1);

    localparam logic [w_tmr-1:0] DWELL_END = w_tmr'(dwell_cycles);
    localparam logic [w_tmr-1:0] BLANK_END = w_tmr'(blank_cycles);
    localparam logic [w_tmr-1:0] TMR_FIRST = w_tmr'(1);
    localparam logic [w_idx-1:0] IDX_LAST  = w_idx'(w_digit - 1);

    scan_state_t      state;
    scan_state_t      state_n;
    logic [w_idx-1:0] idx;
    logic [w_idx-1:0] idx_n;
    logic [w_tmr-1:0] timer;
    logic [w_tmr-1:0] timer_n;
    logic             boundary_n;
    logic             swap;
    logic [w_seg-1:0] rd_seg;

    // timer holds the 1-based cycle count within the current state;
    // 0 only in the reset state so the first post-reset cycle is
    // the first blank cycle of frame 0.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        timer_n = timer + TMR_FIRST;
        unique case (state)
            BLANK: begin
                if (timer == BLANK_END) begin
                    state_n = DRIVE;
                    timer_n = TMR_FIRST;
                end
            end
            DRIVE: begin
                if (timer == DWELL_END) begin
                    state_n = BLANK;
                    timer_n = TMR_FIRST;
                    idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
            end
            default: begin
                state_n = BLANK;
                timer_n = TMR_FIRST;
                idx_n   = '0;
            end
        endcase
        boundary_n = (state_n == BLANK) && (timer_n == TMR_FIRST) &&
                     (idx_n == '0);
    end

    // frame_start marks the boundary cycle, so the copy happens on
    // the edge leaving it and excludes same-cycle writes and commits.
    assign swap = frame_start & commit_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BLANK;
            idx         <= '0;
            timer       <= '0;
            frame_start <= 1'b0;
            commit_pend <= 1'b0;
            hgfedcba    <= '0;
            digit       <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            timer       <= timer_n;
            frame_start <= boundary_n;
            commit_pend <= commit | (commit_pend & ~frame_start);
            if (state_n == DRIVE) begin
                hgfedcba <= rd_seg;
                digit    <= w_digit'(1) << idx_n;
            end else begin
                hgfedcba <= SEG_BLANK;
                digit    <= '0;
            end
        end
    end

    tm1638_seg_buffer #(
        .w_digit (w_digit),
        .w_seg   (w_seg),
        .w_idx   (w_idx)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_idx (wr_idx),
        .wr_seg (wr_seg),
        .swap   (swap),
        .rd_idx (idx_n),
        .rd_seg (rd_seg)
    );

endmodule
